// File: rtl/debug_port_responder_if.sv
// Debug/test port bundle: host request/response signals plus the memory and
// register-file debug ports driven by the responder.
interface debug_port_responder_if #(
    parameter int AW  = 16,
    parameter int DW  = 16,
    parameter int RAW = 4
);
    logic           test;
    logic           memoryoperation;
    logic           registeroperation;
    logic           memorywrite;
    logic           registerwrite;
    logic [AW-1:0]  memaddress;
    logic [DW-1:0]  memwritedata;
    logic [RAW-1:0] registeraddress;
    logic [DW-1:0]  regwritedata;
    logic [DW-1:0]  MD;
    logic [DW-1:0]  RD;
    logic           ack;
    logic           err;
    logic           cpu_enable;
    logic [AW-1:0]  dbg_mem_addr;
    logic [DW-1:0]  dbg_mem_wdata;
    logic           dbg_mem_we;
    logic [DW-1:0]  dbg_mem_rdata;
    logic [RAW-1:0] dbg_reg_addr;
    logic [DW-1:0]  dbg_reg_wdata;
    logic           dbg_reg_we;
    logic [DW-1:0]  dbg_reg_rdata;
    logic           verify_fail;

    modport slave (
        input  test, memoryoperation, registeroperation, memorywrite, registerwrite,
        input  memaddress, memwritedata, registeraddress, regwritedata,
        input  dbg_mem_rdata, dbg_reg_rdata,
        output MD, RD, ack, err, cpu_enable, verify_fail,
        output dbg_mem_addr, dbg_mem_wdata, dbg_mem_we,
        output dbg_reg_addr, dbg_reg_wdata, dbg_reg_we
    );

    modport master (
        output test, memoryoperation, registeroperation, memorywrite, registerwrite,
        output memaddress, memwritedata, registeraddress, regwritedata,
        output dbg_mem_rdata, dbg_reg_rdata,
        input  MD, RD, ack, err, cpu_enable, verify_fail,
        input  dbg_mem_addr, dbg_mem_wdata, dbg_mem_we,
        input  dbg_reg_addr, dbg_reg_wdata, dbg_reg_we
    );
endinterface

// File: rtl/debug_port_responder.sv
// Debug port responder: sequences parked-CPU memory/register requests onto the debug ports.
// Define DEBUG_WRITE_VERIFY_EN to compare write read-back data and raise verify_fail.
module debug_port_responder #(
    parameter int AW  = 16,
    parameter int DW  = 16,
    parameter int RAW = 4
) (
    input logic                   clk,
    input logic                   reset,
    debug_port_responder_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, M_ACC, M_WAIT, M_CAP, R_ACC, R_CAP, DONE
    } state_t;

    state_t         r_state, w_next;
    logic           r_wr;
    logic [AW-1:0]  r_maddr;
    logic [DW-1:0]  r_mwdata;
    logic [RAW-1:0] r_raddr;
    logic [DW-1:0]  r_rwdata;
    logic [DW-1:0]  r_md, r_rd;
    logic           r_ack, r_err, r_req_d;

    logic w_req, w_acc_mem, w_acc_reg, w_abort;
    logic w_cap_mem, w_cap_reg, w_mwe, w_rwe, w_err, w_verr;

    assign w_req = bus.memoryoperation | bus.registeroperation;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_acc_mem = 1'b0;
        w_acc_reg = 1'b0;
        w_abort   = 1'b0;
        w_cap_mem = 1'b0;
        w_cap_reg = 1'b0;
        w_mwe     = 1'b0;
        w_rwe     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!bus.test) begin
                    if (bus.memoryoperation) begin
                        w_acc_mem = 1'b1;
                        w_next    = M_ACC;
                    end else if (bus.registeroperation) begin
                        w_acc_reg = 1'b1;
                        w_next    = R_ACC;
                    end
                end
            end
            M_ACC: begin
                w_mwe  = r_wr;
                w_next = M_WAIT;
            end
            // Second read with we=0 so a write's read-back returns the new word.
            M_WAIT: w_next = M_CAP;
            M_CAP: begin
                w_cap_mem = 1'b1;
                w_next    = DONE;
            end
            R_ACC: begin
                w_rwe  = r_wr;
                w_next = R_CAP;
            end
            R_CAP: begin
                w_cap_reg = 1'b1;
                w_next    = DONE;
            end
            DONE: if (!w_req) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        // CPU reclaiming the bus mid-access: kill strobes and drop the access.
        if (bus.test && r_state != IDLE && r_state != DONE) begin
            w_abort   = 1'b1;
            w_next    = IDLE;
            w_mwe     = 1'b0;
            w_rwe     = 1'b0;
            w_cap_mem = 1'b0;
            w_cap_reg = 1'b0;
        end
    end

    assign w_err = w_abort | w_verr
                 | ((r_state == IDLE) & ~bus.test & bus.memoryoperation & bus.registeroperation)
                 | ((r_state == IDLE) & bus.test & w_req & ~r_req_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr     <= 1'b0;
            r_maddr  <= '0;
            r_mwdata <= '0;
            r_raddr  <= '0;
            r_rwdata <= '0;
            r_md     <= '0;
            r_rd     <= '0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_req_d  <= 1'b0;
        end else begin
            r_req_d <= w_req;
            r_err   <= w_err;
            if (w_acc_mem) begin
                r_maddr  <= bus.memaddress;
                r_mwdata <= bus.memwritedata;
                r_wr     <= bus.memorywrite;
            end
            if (w_acc_reg) begin
                r_raddr  <= bus.registeraddress;
                r_rwdata <= bus.regwritedata;
                r_wr     <= bus.registerwrite;
            end
            if (w_cap_mem) r_md <= bus.dbg_mem_rdata;
            if (w_cap_reg) r_rd <= bus.dbg_reg_rdata;
            if (w_cap_mem | w_cap_reg) r_ack <= 1'b1;
            else if (w_next == IDLE)   r_ack <= 1'b0;
        end
    end

`ifdef DEBUG_WRITE_VERIFY_EN
    logic r_vfail;

    assign w_verr = r_wr & ((w_cap_mem & (bus.dbg_mem_rdata != r_mwdata))
                          | (w_cap_reg & (bus.dbg_reg_rdata != r_rwdata)));

    // Sticky until the next accepted write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_vfail <= 1'b0;
        else if ((w_acc_mem & bus.memorywrite) | (w_acc_reg & bus.registerwrite))
            r_vfail <= 1'b0;
        else if (w_verr)
            r_vfail <= 1'b1;
    end

    assign bus.verify_fail = r_vfail;
`else
    assign w_verr          = 1'b0;
    assign bus.verify_fail = 1'b0;
`endif

    assign bus.MD            = r_md;
    assign bus.RD            = r_rd;
    assign bus.ack           = r_ack;
    assign bus.err           = r_err;
    assign bus.cpu_enable    = bus.test & (r_state == IDLE) & ~reset;
    assign bus.dbg_mem_addr  = r_maddr;
    assign bus.dbg_mem_wdata = r_mwdata;
    assign bus.dbg_mem_we    = w_mwe;
    assign bus.dbg_reg_addr  = r_raddr;
    assign bus.dbg_reg_wdata = r_rwdata;
    assign bus.dbg_reg_we    = w_rwe;

endmodule

// File: doc/debug_port_responder.md
Name: debug_port_responder

Overview:
- Target-side responder for the SystemTest debug/test port.
- Accepts the level-held memory and register requests driven by the bench or host while the CPU is parked (test=0).
- Sequences each request onto the memory and register-file debug ports, then returns read or read-back data on MD/RD with an explicit ack.
- Gates CPU execution via cpu_enable so debug and CPU accesses never overlap.

Parameters:
- AW, 16, memory address width
- DW, 16, data width for memory and registers
- RAW, 4, register address width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- test  in  1  1 = CPU runs; 0 = debug port owns memory and registers
- memoryoperation  in  1  memory request, level-held until ack
- registeroperation  in  1  register request, level-held until ack
- memorywrite  in  1  qualifies memoryoperation as a write
- registerwrite  in  1  qualifies registeroperation as a write
- memaddress  in  AW  memory address
- memwritedata  in  DW  memory write data
- registeraddress  in  RAW  register index
- regwritedata  in  DW  register write data
- MD  out  DW  memory read/read-back data (registered)
- RD  out  DW  register read/read-back data (registered)
- ack  out  1  request complete; MD/RD valid
- err  out  1  one-cycle pulse on a protocol violation
- cpu_enable  out  1  CPU may advance
- dbg_mem_addr  out  AW  memory debug address
- dbg_mem_wdata  out  DW  memory debug write data
- dbg_mem_we  out  1  memory debug write strobe
- dbg_mem_rdata  in  DW  memory data, synchronous read, 1-cycle latency, read-first
- dbg_reg_addr  out  RAW  register debug address
- dbg_reg_wdata  out  DW  register debug write data
- dbg_reg_we  out  1  register debug write strobe
- dbg_reg_rdata  in  DW  register data, combinational read
- verify_fail  out  1  read-back mismatch (optional feature)

Behaviour:
- Reset (async): state IDLE; MD=0, RD=0, ack=0, err=0, cpu_enable=0, all dbg_* outputs 0, verify_fail=0.
- cpu_enable = test & (state==IDLE). It is registered-state based, so it drops in the same cycle a request is accepted.
- States: IDLE, M_ACC, M_WAIT, M_CAP, R_ACC, R_CAP, DONE.
- IDLE:
  - Samples requests only when test=0; address, data and write flag are latched at the accepting edge.
  - memoryoperation -> M_ACC.
  - Otherwise registeroperation -> R_ACC.
  - Both asserted: memory wins and err pulses.
  - Request seen while test=1: ignored, err pulses once per rising edge of the request.
- Memory path, 3-cycle latency:
  - M_ACC: drive dbg_mem_addr; dbg_mem_we = latched write flag, asserted exactly this one cycle.
  - M_WAIT: re-issue the read with we=0, so write read-back sees the new data.
  - M_CAP: at the next edge MD <= dbg_mem_rdata, ack <= 1, go to DONE.
  - Reads take the same path; latency is uniform.
- Register path, 2-cycle latency:
  - R_ACC: dbg_reg_we = latched write flag for one cycle.
  - R_CAP: at the next edge RD <= dbg_reg_rdata, ack <= 1, go to DONE.
- DONE:
  - ack held high; MD/RD stable.
  - When memoryoperation and registeroperation are both 0, go to IDLE and drop ack at that edge.
  - Changes to address or data while in DONE are ignored.
- Abort: test rising in any non-IDLE, non-DONE state forces dbg_*_we=0 combinationally, returns to IDLE, pulses err, and leaves MD/RD unchanged.
- Address/data wrap: none. Values are truncated to AW/DW/RAW. Register index 0 is writable; the register file owns any hardwiring.
- Back-to-back requests: a new request is accepted only after one IDLE cycle following DONE.

Optional Feature:
- Macro: DEBUG_WRITE_VERIFY_EN.
- Defined: on a write, the captured read-back is compared with the latched write data. On mismatch, verify_fail is set sticky (cleared by reset or by the next accepted write) and err pulses with ack.
- Undefined: no comparator; verify_fail tied 0.

Test Plan:
- Memory write, test=0, memaddress=0x0005, memwritedata=0xBE07 -> dbg_mem_we high exactly 1 cycle; ack on 3rd edge after accept; MD=0xBE07.
- Register write, registeraddress=0, regwritedata=2310 (0x0906) -> dbg_reg_we 1 cycle; ack on 2nd edge; RD=0x0906. Release the request -> ack=0, then cpu_enable=1 once test=1.
- Memory and register requests asserted simultaneously -> memory access only; err pulse; dbg_reg_we never asserted.
- Request while test=1 -> no dbg_* activity, single err pulse; raise test during M_ACC -> we forced 0, IDLE, err, MD keeps its old value.
- Reset asserted asynchronously mid-M_WAIT -> all outputs 0 immediately; after release, a read of memaddress=0x0001 returns the stored 0xFE0F.
- With DEBUG_WRITE_VERIFY_EN, memory model forced to return 0x0000 on a write of 0x1234 -> verify_fail=1, err pulse; a next correct write clears verify_fail.
